// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit with private data memory, valid/ready request and one-cycle response pulse.
// Build option LSU_MISALIGN_CHK_EN: misaligned H/W accesses report resp_err instead of being force-aligned.
module dmem_lsu #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_re,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

`ifdef LSU_MISALIGN_CHK_EN
  localparam logic CHK_MISALIGN = 1'b1;
`else
  localparam logic CHK_MISALIGN = 1'b0;
`endif

  // Illegal size codes, unsigned stores and (optionally) misalignment all abort the access.
  function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] lane);
    logic err;
    case (f3)
      F3_B:    err = 1'b0;
      F3_H:    err = CHK_MISALIGN & lane[0];
      F3_W:    err = CHK_MISALIGN & (|lane);
      F3_BU:   err = we;
      F3_HU:   err = we;
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    res = {{24{b[7]}}, b};
      F3_H:    res = {{16{h[15]}}, h};
      F3_W:    res = word;
      F3_BU:   res = {24'h000000, b};
      F3_HU:   res = {16'h0000, h};
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
    logic [3:0] be;
    case (f3)
      F3_B:    be = 4'b0001 << lane;
      F3_H:    be = lane[1] ? 4'b1100 : 4'b0011;
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wdata);
    logic [31:0] d;
    case (f3)
      F3_B:    d = {4{wdata[7:0]}};
      F3_H:    d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          accept_s;
  logic          access_s;
  logic          err_s;
  logic          wr_en_s;
  logic [AW-1:0] widx_s;
  logic [31:0]   rd_word_s;
  logic [3:0]    be_s;
  logic [31:0]   wr_data_s;
  logic          unused_s;

  assign unused_s  = ^req_addr[31:AW+2];
  assign accept_s  = req_valid & (state_q == S_IDLE) & (req_we | req_re);
  assign access_s  = (state_q == S_WAIT) & (cnt_q == 4'd0);
  assign widx_s    = addr_q[AW+1:2];
  assign rd_word_s = mem_q[widx_s];
  assign err_s     = access_err(we_q, f3_q, addr_q[1:0]);
  assign wr_en_s   = access_s & we_q & ~err_s;
  assign be_s      = store_be(f3_q, addr_q[1:0]);
  assign wr_data_s = store_data(f3_q, wdata_q);

  // Next-state logic: request capture, wait countdown, access and response generation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    f3_d         = f3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    rdata_d      = 32'h0000_0000;
    err_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = S_WAIT;
          cnt_d   = CNT_INIT;
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr[AW+1:0];
          wdata_d = req_wdata;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          err_d        = err_s;
          rdata_d      = (err_s | we_q) ? 32'h0000_0000 : load_extract(rd_word_s, f3_q, addr_q[1:0]);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= 32'h0000_0000;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'h0000_0000;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Data memory: byte-lane write on the WAIT->RESP edge; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) mem_q[widx_s][b*8 +: 8] <= wr_data_s[b*8 +: 8];
      end
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = ~req_ready;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed vector table, hand-written multi-cycle sequences,
// and randomized traffic against a byte-array reference model.
module tb_dmem_lsu;

  localparam int DEPTH = 1024;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic        req_re = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] mdl [4*DEPTH];

  dmem_lsu #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_re(req_re), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic        re;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic we, logic re, logic [2:0] f3, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] exp_rd, logic exp_err);
    vec_t v;
    v.name = name; v.we = we; v.re = re; v.f3 = f3; v.addr = addr;
    v.wdata = wdata; v.exp_rd = exp_rd; v.exp_err = exp_err;
    return v;
  endfunction

  // Reference model: memory as a flat byte array, access size and extension computed arithmetically.
  function automatic void model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                       input logic [31:0] wdata, output logic [31:0] rd,
                                       output logic err);
    int     size;
    int     base;
    longint val;
    rd  = 32'h0;
    err = 1'b0;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    if (size == 0) err = 1'b1;
    if (we && f3 >= 3'd4) err = 1'b1;
    base = int'(addr % 32'(4*DEPTH));
`ifdef LSU_MISALIGN_CHK_EN
    if (size > 1 && (base % size) != 0) err = 1'b1;
`endif
    if (err) return;
    base = base - (base % size);
    if (we) begin
      for (int i = 0; i < size; i++) mdl[base+i] = 8'((wdata >> (8*i)) & 32'hFF);
    end else begin
      val = 0;
      for (int i = 0; i < size; i++) val += longint'(mdl[base+i]) << (8*i);
      if (f3 < 3'd4 && size < 4 && val >= (longint'(1) << (8*size-1))) val -= longint'(1) << (8*size);
      rd = 32'(val);
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One request/response exchange; lat counts cycles from the handshake cycle to resp_valid.
  task automatic xact(input logic we, input logic re, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rd, output logic err,
                      output int lat, output logic hs_ok);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_re = re; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    lat = -1; rd = 32'h0; err = 1'b0; hs_ok = (n < 50);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (req_ready || !busy) hs_ok = 1'b0;
      if (resp_valid) begin
        lat = k; rd = resp_rdata; err = resp_err;
        break;
      end
    end
    @(negedge clk);
    if (resp_valid || resp_rdata != 32'h0 || resp_err || !req_ready) hs_ok = 1'b0;
  endtask

  task automatic run_check(input string name, input logic we, input logic re, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        err;
    int          lat;
    logic        hs_ok;
    xact(we, re, f3, addr, wdata, rd, err, lat, hs_ok);
    chk({name, "_rdata"}, rd, exp_rd);
    chk({name, "_err"}, 32'(err), 32'(exp_err));
    chk({name, "_lat"}, 32'(lat), 32'(LAT + 1));
    chk({name, "_handshake"}, 32'(hs_ok), 32'd1);
  endtask

  initial begin
    logic [31:0] mrd;
    logic        merr;
    logic [31:0] d;
    logic        ok;
    int          acc [3];
    int          k;
    int          nresp;
    logic [31:0] bb_addr [3];
    logic [31:0] bb_data [3];

    // Reset state
    #12;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Fill words 0..127 with random data so every later load has a defined expectation
    for (int w = 0; w < 128; w++) begin
      d = $urandom();
      model_access(1'b1, 3'b010, 32'(w*4), d, mrd, merr);
      run_check("init_sw", 1'b1, 1'b0, 3'b010, 32'(w*4), d, 32'h0, 1'b0);
    end

    // Directed vector table
    vecs.push_back(mk("sw80",    1, 0, 3'b010, 32'h80,  32'h8081F0FF, 32'h0,        0));
    vecs.push_back(mk("lb80",    0, 1, 3'b000, 32'h80,  32'h0,        32'hFFFFFFFF, 0));
    vecs.push_back(mk("lbu83",   0, 1, 3'b100, 32'h83,  32'h0,        32'h00000080, 0));
    vecs.push_back(mk("lh82",    0, 1, 3'b001, 32'h82,  32'h0,        32'hFFFF8081, 0));
    vecs.push_back(mk("lhu80",   0, 1, 3'b101, 32'h80,  32'h0,        32'h0000F0FF, 0));
    vecs.push_back(mk("lw80",    0, 1, 3'b010, 32'h80,  32'h0,        32'h8081F0FF, 0));
    vecs.push_back(mk("sw10",    1, 0, 3'b010, 32'h10,  32'h11223344, 32'h0,        0));
    vecs.push_back(mk("sb11",    1, 0, 3'b000, 32'h11,  32'h000000AA, 32'h0,        0));
    vecs.push_back(mk("lw10a",   0, 1, 3'b010, 32'h10,  32'h0,        32'h1122AA44, 0));
    vecs.push_back(mk("sh12",    1, 0, 3'b001, 32'h12,  32'hFFFF5566, 32'h0,        0));
    vecs.push_back(mk("lw10b",   0, 1, 3'b010, 32'h10,  32'h0,        32'h5566AA44, 0));
    vecs.push_back(mk("sw100",   1, 0, 3'b010, 32'h100, 32'hCAFEBABE, 32'h0,        0));
`ifdef LSU_MISALIGN_CHK_EN
    vecs.push_back(mk("lw102",   0, 1, 3'b010, 32'h102, 32'h0,        32'h0,        1));
    vecs.push_back(mk("lh81",    0, 1, 3'b001, 32'h81,  32'h0,        32'h0,        1));
`else
    vecs.push_back(mk("lw102",   0, 1, 3'b010, 32'h102, 32'h0,        32'hCAFEBABE, 0));
    vecs.push_back(mk("lh81",    0, 1, 3'b001, 32'h81,  32'h0,        32'hFFFFF0FF, 0));
`endif
    vecs.push_back(mk("ld011",   0, 1, 3'b011, 32'h80,  32'h0,        32'h0,        1));
    vecs.push_back(mk("sbu80",   1, 0, 3'b100, 32'h80,  32'h00000055, 32'h0,        1));
    vecs.push_back(mk("st111",   1, 0, 3'b111, 32'h80,  32'h12345678, 32'h0,        1));
    vecs.push_back(mk("lw80chk", 0, 1, 3'b010, 32'h80,  32'h0,        32'h8081F0FF, 0));
    vecs.push_back(mk("swre84",  1, 1, 3'b010, 32'h84,  32'h13579BDF, 32'h0,        0));
    vecs.push_back(mk("lbu85",   0, 1, 3'b100, 32'h85,  32'h0,        32'h0000009B, 0));
    vecs.push_back(mk("lb86",    0, 1, 3'b000, 32'h86,  32'h0,        32'h00000057, 0));
    foreach (vecs[i]) begin
      model_access(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, mrd, merr);
      run_check(vecs[i].name, vecs[i].we, vecs[i].re, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_rd, vecs[i].exp_err);
    end

    // Request with neither load nor store is ignored
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_re = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!req_ready || resp_valid) ok = 1'b0;
    end
    req_valid = 1'b0;
    chk("noop_ignored", 32'(ok), 32'd1);

    // Reset asserted mid-WAIT drops the pending store
    model_access(1'b0, 3'b010, 32'h40, 32'h0, mrd, merr);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_re = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h40; req_wdata = 32'hDEADBEEF;
    @(negedge clk);
    req_valid = 1'b0;
    chk("t1_busy_in_wait", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("t1_rst_ready", 32'(req_ready), 32'd1);
    chk("t1_rst_valid", 32'(resp_valid), 32'd0);
    chk("t1_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_check("t1_lw40", 1'b0, 1'b1, 3'b010, 32'h40, 32'h0, mrd, 1'b0);

    // Back-to-back stores with req_valid held high; first one aliases word 1
    bb_addr[0] = 32'h1004; bb_data[0] = 32'hA5A50001;
    bb_addr[1] = 32'h0008; bb_data[1] = 32'hA5A50002;
    bb_addr[2] = 32'h000C; bb_data[2] = 32'hA5A50003;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    k = 0; nresp = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_re = 1'b0; req_funct3 = 3'b010;
    req_addr = bb_addr[0]; req_wdata = bb_data[0];
    for (int t = 0; t < 60; t++) begin
      if (resp_valid) nresp++;
      if (req_valid && req_ready) begin
        acc[k] = t;
        k++;
      end else if (k < 3) begin
        req_addr = bb_addr[k]; req_wdata = bb_data[k];
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) model_access(1'b1, 3'b010, bb_addr[i], bb_data[i], mrd, merr);
    chk("b2b_accepts", 32'(k), 32'd3);
    chk("b2b_resps", 32'(nresp), 32'd3);
    chk("b2b_gap01", 32'(acc[1] - acc[0]), 32'(LAT + 2));
    chk("b2b_gap12", 32'(acc[2] - acc[1]), 32'(LAT + 2));
    run_check("alias_lw04", 1'b0, 1'b1, 3'b010, 32'h0004, 32'h0, 32'hA5A50001, 1'b0);
    run_check("lw0c", 1'b0, 1'b1, 3'b010, 32'h000C, 32'h0, 32'hA5A50003, 1'b0);

    // Randomized traffic over the initialised region with random upper address bits
    for (int i = 0; i < 200; i++) begin
      logic        we;
      logic        re;
      logic [2:0]  f3;
      logic [31:0] addr;
      we   = 1'($urandom_range(0, 1));
      re   = we ? 1'($urandom_range(0, 1)) : 1'b1;
      f3   = 3'($urandom_range(0, 7));
      addr = ($urandom() & 32'hFFFFF000) | 32'($urandom_range(0, 511));
      d    = $urandom();
      model_access(we, f3, addr, d, mrd, merr);
      run_check("rand", we, re, f3, addr, d, mrd, merr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
